// File: rtl/ctl_gpr_pipe.sv
// Clocked 4-phase bundled-data micropipeline of DEPTH C-element stages with a
// transfer counter and sticky protocol-error flag. Optional: CTL_GPR_PIPE_SYNC_EN.
module ctl_gpr_pipe #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              ack_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              req_o,
  input  logic              ack_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  xfer_cnt_o,
  output logic              err_o
);

  logic req_s;
  logic ack_s;

`ifdef CTL_GPR_PIPE_SYNC_EN
  // Two-flop synchronisers; every downstream use sees the synchronised copy
  logic [1:0] req_sync;
  logic [1:0] ack_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_sync <= '0;
      ack_sync <= '0;
    end else begin
      req_sync <= {req_sync[0], req_i};
      ack_sync <= {ack_sync[0], ack_o};
    end
  end

  assign req_s = req_sync[1];
  assign ack_s = ack_sync[1];
`else
  assign req_s = req_i;
  assign ack_s = ack_o;
`endif

  logic [DEPTH-1:0]  s;
  logic [DEPTH-1:0]  s_nxt;
  logic [DEPTH-1:0]  left;
  logic [DEPTH-1:0]  right;
  logic [DEPTH-1:0]  rise;
  logic [DATA_W-1:0] d   [DEPTH];
  logic [DATA_W-1:0] src [DEPTH];

  // Neighbour views: left is the previous stage (req_s at the head), right the
  // next stage (ack_s at the tail); shifting a concatenation keeps DEPTH=1 legal.
  always_comb begin
    left  = DEPTH'({s, req_s});
    right = DEPTH'({ack_s, s} >> 1);
    s_nxt = (left & ~right) | (s & (left | ~right));
    rise  = s_nxt & ~s;
    src[0] = data_i;
    for (int k = 1; k < DEPTH; k++) begin
      src[k] = d[k-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= '0;
      end
    end else begin
      s <= s_nxt;
      for (int k = 0; k < DEPTH; k++) begin
        if (rise[k]) begin
          d[k] <= src[k];
        end
      end
    end
  end

  assign ack_i  = s[0];
  assign req_o  = s[DEPTH-1];
  assign data_o = d[DEPTH-1];

  logic req_q;
  logic ack_q;
  logic cnt_inc;
  logic err_set;

  // Counter counts ack rising edges against a live request; errors are observational
  always_comb begin
    cnt_inc = ack_s & ~ack_q & req_o;
    err_set = (~req_s & req_q & ~ack_i)
            | (ack_s & ~ack_q & ~req_o)
            | (~ack_s & ack_q & req_o);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q      <= 1'b0;
      ack_q      <= 1'b0;
      xfer_cnt_o <= '0;
      err_o      <= 1'b0;
    end else begin
      req_q <= req_s;
      ack_q <= ack_s;
      if (cnt_inc) begin
        xfer_cnt_o <= xfer_cnt_o + CNT_W'(1);
      end
      if (err_set) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ctl_gpr_pipe.sv
// Scoreboard bench for ctl_gpr_pipe: latency, stall, ordering, counter, errors, reset.
// Latency expectations follow CTL_GPR_PIPE_SYNC_EN when it is defined.
module tb_ctl_gpr_pipe;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;
`ifdef CTL_GPR_PIPE_SYNC_EN
  localparam int unsigned SYNC_LAT = 2;
`else
  localparam int unsigned SYNC_LAT = 0;
`endif
  localparam int unsigned TMO = 60;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_i;
  logic              ack_i;
  logic [DATA_W-1:0] data_i;
  logic              req_o;
  logic              ack_o;
  logic [DATA_W-1:0] data_o;
  logic [CNT_W-1:0]  xfer_cnt;
  logic              err;

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  ctl_gpr_pipe #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .ack_i(ack_i), .data_i(data_i),
    .req_o(req_o), .ack_o(ack_o), .data_o(data_o), .xfer_cnt_o(xfer_cnt), .err_o(err)
  );

  always #5 clk = ~clk;

  // Producer handshake; pushes the token once the pipe acknowledges it
  task automatic send(input logic [DATA_W-1:0] dv, output bit ok);
    int n;
    ok = 1'b1;
    data_i = dv;
    req_i = 1'b1;
    n = 0;
    while (ack_i !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    if (ack_i !== 1'b1) ok = 1'b0;
    else exp_q.push_back(dv);
    req_i = 1'b0;
    n = 0;
    while (ack_i !== 1'b0 && n < TMO) begin @(negedge clk); n++; end
    if (ack_i !== 1'b0) ok = 1'b0;
  endtask

  // Consumer handshake; returns the payload seen while req_o is high
  task automatic recv(output logic [DATA_W-1:0] got, output bit ok);
    int n;
    ok = 1'b1;
    got = '0;
    n = 0;
    while (req_o !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    if (req_o !== 1'b1) begin
      ok = 1'b0;
    end else begin
      got = data_o;
      ack_o = 1'b1;
      n = 0;
      while (req_o !== 1'b0 && n < TMO) begin @(negedge clk); n++; end
      if (req_o !== 1'b0) ok = 1'b0;
      ack_o = 1'b0;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; req_i = 1'b0; ack_o = 1'b0; data_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({ack_i, req_o, data_o, xfer_cnt, err} !== '0) begin
        failures++;
        $display("FAIL idle_c%0d: ack_i=%b req_o=%b data_o=%h cnt=%0d err=%b, want all 0",
                 c, ack_i, req_o, data_o, xfer_cnt, err);
      end
    end
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] e;
    int n;
    data_i = 8'hA5; req_i = 1'b1;
    repeat (SYNC_LAT) @(negedge clk);
    checks++; if (ack_i !== 1'b0) begin failures++; $display("FAIL ack_early: got %b want 0", ack_i); end
    @(negedge clk);
    checks++; if (ack_i !== 1'b1) begin failures++; $display("FAIL ack_latency: got %b want 1", ack_i); end
    exp_q.push_back(8'hA5);
    repeat (DEPTH - 2) @(negedge clk);
    checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL req_early: got %b want 0", req_o); end
    @(negedge clk);
    checks++; if (req_o !== 1'b1) begin failures++; $display("FAIL req_latency: got %b want 1", req_o); end
    e = exp_q.pop_front();
    checks++; if (data_o !== e) begin failures++; $display("FAIL single_data: got %h want %h", data_o, e); end
    req_i = 1'b0;
    repeat (1 + SYNC_LAT) @(negedge clk);
    checks++; if (ack_i !== 1'b0) begin failures++; $display("FAIL ack_fall: got %b want 0", ack_i); end
    ack_o = 1'b1;
    repeat (1 + SYNC_LAT) @(negedge clk);
    checks++; if (xfer_cnt !== 16'd1) begin failures++; $display("FAIL single_cnt: got %0d want 1", xfer_cnt); end
    n = 0;
    while (req_o !== 1'b0 && n < TMO) begin @(negedge clk); n++; end
    checks++; if (req_o !== 1'b0) begin failures++; $display("FAIL req_fall: got %b want 0", req_o); end
    ack_o = 1'b0;
    repeat (SYNC_LAT + 3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int hi;
    send(8'h11, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_send1: handshake timed out"); end
    send(8'h22, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_send2: handshake timed out"); end
    data_i = 8'h33; req_i = 1'b1;
    hi = 0;
    repeat (10) begin @(negedge clk); if (ack_i !== 1'b0) hi++; end
    checks++; if (hi != 0) begin failures++; $display("FAIL b2b_stall: ack_i high %0d cycles, want 0", hi); end
    checks++; if (req_o !== 1'b1 || data_o !== 8'h11) begin
      failures++; $display("FAIL b2b_head: req_o=%b data_o=%h, want 1/11", req_o, data_o);
    end
    fork
      begin
        int n;
        n = 0;
        while (ack_i !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        checks++; if (ack_i !== 1'b1) begin failures++; $display("FAIL b2b_send3: ack_i=%b want 1", ack_i); end
        else exp_q.push_back(8'h33);
        req_i = 1'b0;
        n = 0;
        while (ack_i !== 1'b0 && n < TMO) begin @(negedge clk); n++; end
      end
      begin
        logic [DATA_W-1:0] got, e;
        bit rok;
        for (int i = 0; i < 3; i++) begin
          recv(got, rok);
          checks++;
          if (!rok || exp_q.size() == 0) begin
            failures++; $display("FAIL b2b_recv%0d: ok=%b queued=%0d, want delivery", i, rok, exp_q.size());
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin failures++; $display("FAIL b2b_data%0d: got %h want %h", i, got, e); end
          end
        end
      end
    join
    repeat (SYNC_LAT + 3) @(negedge clk);
    checks++; if (xfer_cnt !== 16'd4) begin failures++; $display("FAIL b2b_cnt: got %0d want 4", xfer_cnt); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL b2b_err: got %b want 0", err); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    logic [DATA_W-1:0] got, e;
    send(8'h55, ok);
    recv(got, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || got !== e) begin failures++; $display("FAIL pre_data: got %h want %h", got, e); end
    repeat (SYNC_LAT + 3) @(negedge clk);
    send(8'h66, ok);
    n = 0;
    while (req_o !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    checks++; if (req_o !== 1'b1 || xfer_cnt !== 16'd5) begin
      failures++; $display("FAIL pre_reset: req_o=%b cnt=%0d, want 1/5", req_o, xfer_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ack_i, req_o, data_o, xfer_cnt, err} !== '0) begin
      failures++; $display("FAIL async_reset: ack_i=%b req_o=%b data_o=%h cnt=%0d err=%b, want all 0",
                           ack_i, req_o, data_o, xfer_cnt, err);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h77, ok);
    recv(got, ok);
    checks++;
    if (!ok || exp_q.size() == 0) begin failures++; $display("FAIL post_reset_recv: ok=%b, want delivery", ok); end
    else begin
      e = exp_q.pop_front();
      if (got !== e) begin failures++; $display("FAIL post_reset_data: got %h want %h", got, e); end
    end
    repeat (SYNC_LAT + 2) @(negedge clk);
    checks++; if (xfer_cnt !== 16'd1) begin failures++; $display("FAIL post_reset_cnt: got %0d want 1", xfer_cnt); end
  endtask

  task automatic test_spurious_ack();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_pre: got %b want 0", err); end
    ack_o = 1'b1;
    repeat (1 + SYNC_LAT) @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_spurious: got %b want 1", err); end
    ack_o = 1'b0;
    repeat (SYNC_LAT + 5) @(negedge clk);
    checks++; if (err !== 1'b1 || xfer_cnt !== 16'd1) begin
      failures++; $display("FAIL err_sticky: err=%b cnt=%0d, want 1/1", err, xfer_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear: got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_withdrawn_req();
    bit ok;
    logic [DATA_W-1:0] got, e;
    send(8'h81, ok);
    send(8'h82, ok);
    data_i = 8'h83; req_i = 1'b1;
    repeat (4 + SYNC_LAT) @(negedge clk);
    checks++; if (ack_i !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL wd_pre: ack_i=%b err=%b, want 0/0", ack_i, err);
    end
    req_i = 1'b0;
    repeat (1 + SYNC_LAT) @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_withdrawn: got %b want 1", err); end
    for (int i = 0; i < 2; i++) begin
      recv(got, ok);
      checks++;
      if (!ok || exp_q.size() == 0) begin failures++; $display("FAIL wd_recv%0d: ok=%b, want delivery", i, ok); end
      else begin
        e = exp_q.pop_front();
        if (got !== e) begin failures++; $display("FAIL wd_data%0d: got %h want %h", i, got, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_spurious_ack();
    test_withdrawn_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
